// File: rtl/subset_update_writer.sv
// subset_update_writer: insert/delete read-check-write engine for one subset's group tables.
// Each accepted command reads its entry, checks it, then writes it back or reports why not.
module subset_update_writer #(
    parameter int NUM_GROUPS = 5,
    parameter int G0_SIZE    = 1738,
    parameter int G1_SIZE    = 154,
    parameter int G2_SIZE    = 18,
    parameter int G3_SIZE    = 0,
    parameter int G4_SIZE    = 29,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   command,
    input  logic [2:0]   cmd_group,
    input  logic [10:0]  cmd_index,
    input  logic [103:0] cmd_tuple,
    input  logic [10:0]  cmd_ruleID,
    output logic         mem_re,
    output logic         mem_we,
    output logic [2:0]   mem_group,
    output logic [10:0]  mem_addr,
    output logic [115:0] mem_wdata,
    input  logic [115:0] mem_rdata,
    output logic         done,
    output logic [1:0]   status,
    output logic         busy,
    output logic [15:0]  update_count
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_DONE} state_t;
    localparam logic [1:0] CMD_NOP = 2'b00, CMD_INS = 2'b01, CMD_DEL = 2'b10, CMD_RSV = 2'b11;
    localparam logic [1:0] ST_OK = 2'b00, ST_COLL = 2'b01, ST_NF = 2'b10, ST_BAD = 2'b11;
    state_t         r_state;
    logic           r_ready, r_busy, r_mem_re, r_mem_we, r_done, r_is_del;
    logic [2:0]     r_mem_group;
    logic [10:0]    r_mem_addr, r_rule;
    logic [115:0]   r_wdata;
    logic [1:0]     r_status, r_wait;
    logic [15:0]    r_update_count;
    logic [103:0]   r_tuple;
    logic [11:0]    w_size;
    logic           w_bad, w_coll, w_miss, w_unused_rule;
    assign w_size = cmd_group == 3'd0 ? 12'(G0_SIZE) :
                    cmd_group == 3'd1 ? 12'(G1_SIZE) :
                    cmd_group == 3'd2 ? 12'(G2_SIZE) :
                    cmd_group == 3'd3 ? 12'(G3_SIZE) :
                    cmd_group == 3'd4 ? 12'(G4_SIZE) : 12'd0;
    // a zero-size table makes every index out of range through the same compare
    assign w_bad  = command == CMD_RSV || int'(cmd_group) >= NUM_GROUPS || {1'b0, cmd_index} >= w_size;
    assign w_coll = !r_is_del && mem_rdata[115];
    assign w_miss = r_is_del && (!mem_rdata[115] || mem_rdata[114:11] != r_tuple);
    assign w_unused_rule = ^mem_rdata[10:0];
    assign cmd_ready    = r_ready;
    assign busy         = r_busy;
    assign mem_re       = r_mem_re;
    assign mem_we       = r_mem_we;
    assign mem_group    = r_mem_group;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_wdata;
    assign done         = r_done;
    assign status       = r_status;
    assign update_count = r_update_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_mem_re       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_done         <= 1'b0;
            r_status       <= ST_OK;
            r_update_count <= '0;
            r_mem_group    <= '0;
            r_mem_addr     <= '0;
            r_wdata        <= '0;
            r_is_del       <= 1'b0;
            r_tuple        <= '0;
            r_rule         <= '0;
            r_wait         <= '0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            r_wdata  <= '0;
            case (r_state)
                S_IDLE: if (cmd_valid && command != CMD_NOP) begin
                    r_is_del <= command == CMD_DEL;
                    r_tuple  <= cmd_tuple;
                    r_rule   <= cmd_ruleID;
                    r_ready  <= 1'b0;
                    r_busy   <= 1'b1;
                    if (w_bad) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_status <= ST_BAD;
                    end else begin
                        r_state     <= S_READ;
                        r_mem_re    <= 1'b1;
                        r_mem_group <= cmd_group;
                        r_mem_addr  <= cmd_index;
                    end
                end
                S_READ: begin
                    r_state <= RD_LATENCY > 1 ? S_WAIT : S_CHECK;
                    r_wait  <= 2'(RD_LATENCY - 2);
                end
                S_WAIT: begin
                    r_state <= r_wait == 2'd0 ? S_CHECK : S_WAIT;
                    r_wait  <= r_wait - 2'd1;
                end
                S_CHECK: if (w_coll || w_miss) begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_status <= w_coll ? ST_COLL : ST_NF;
                end else begin
                    r_state  <= S_WRITE;
                    r_mem_we <= 1'b1;
                    r_wdata  <= r_is_del ? 116'd0 : {1'b1, r_tuple, r_rule};
                end
                S_WRITE: begin
                    r_state        <= S_DONE;
                    r_done         <= 1'b1;
                    r_status       <= ST_OK;
                    r_update_count <= r_update_count + 16'(r_update_count != 16'hFFFF);
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_subset_update_writer.sv
// tb_subset_update_writer: scoreboard bench for subset_update_writer at read latency 1 and 3.
module tb_subset_update_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         rst, rst3, cmd_valid, cmd_valid3;
    logic [1:0]   command;
    logic [2:0]   cmd_group;
    logic [10:0]  cmd_index, cmd_ruleID;
    logic [103:0] cmd_tuple;
    logic         cmd_ready, mem_re, mem_we, done, busy;
    logic [2:0]   mem_group;
    logic [10:0]  mem_addr;
    logic [115:0] mem_wdata, mem_rdata;
    logic [1:0]   status;
    logic [15:0]  update_count;
    logic         cmd_ready3, mem_re3, mem_we3, done3, busy3;
    logic [2:0]   mem_group3;
    logic [10:0]  mem_addr3;
    logic [115:0] mem_wdata3, mem_rdata3;
    logic [1:0]   status3;
    logic [15:0]  update_count3;
    subset_update_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .command(command),
        .cmd_group(cmd_group), .cmd_index(cmd_index), .cmd_tuple(cmd_tuple), .cmd_ruleID(cmd_ruleID),
        .mem_re(mem_re), .mem_we(mem_we), .mem_group(mem_group), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .status(status), .busy(busy),
        .update_count(update_count));
    subset_update_writer #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .command(command),
        .cmd_group(cmd_group), .cmd_index(cmd_index), .cmd_tuple(cmd_tuple), .cmd_ruleID(cmd_ruleID),
        .mem_re(mem_re3), .mem_we(mem_we3), .mem_group(mem_group3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .done(done3), .status(status3), .busy(busy3),
        .update_count(update_count3));
    // table memory for the latency-1 engine; preload port lets the bench seed entries
    logic [115:0] tab [5][2048];
    logic         pl_we = 1'b0;
    logic [2:0]   pl_g;
    logic [10:0]  pl_a;
    logic [115:0] pl_d;
    always @(posedge clk) begin
        if (pl_we) tab[pl_g][pl_a] <= pl_d;
        else if (mem_we && mem_group < 3'd5) tab[mem_group][mem_addr] <= mem_wdata;
        mem_rdata <= (mem_re && mem_group < 3'd5) ? tab[mem_group][mem_addr] : '0;
    end
    // latency-3 responder: returns rd3_val only in the cycle data is due
    logic [1:0]   p3 = '0;
    logic [115:0] rd3_val = '0;
    always @(posedge clk) begin
        p3 <= {p3[0], mem_re3};
        mem_rdata3 <= p3[1] ? rd3_val : '0;
    end
    int both_n = 0, wd_n = 0, we3_n = 0;
    always @(posedge clk) begin
        if ((mem_re && mem_we) || (mem_re3 && mem_we3)) both_n <= both_n + 1;
        if ((!mem_we && mem_wdata != '0) || (!mem_we3 && mem_wdata3 != '0)) wd_n <= wd_n + 1;
        if (mem_we3) we3_n <= we3_n + 1;
    end
    int total = 0, bad = 0, mcount = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int gsize(input logic [2:0] g);
        return g == 0 ? 1738 : g == 1 ? 154 : g == 2 ? 18 : g == 4 ? 29 : 0;
    endfunction
    task automatic preload(input logic [2:0] g, input logic [10:0] a, input logic [115:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_g = g; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask
    function automatic logic [103:0] rnd_tuple();
        return {$urandom, $urandom, $urandom, 8'($urandom)};
    endfunction
    task automatic do_cmd(input logic [1:0] c, input logic [2:0] g, input logic [10:0] i,
                          input logic [103:0] t, input logic [10:0] r);
        logic [115:0] old, nv, wq;
        logic [13:0]  raddr, waddr;
        logic         isbad;
        logic [1:0]   est;
        int elat, lat, re_at, we_at, nre, nwe, busy_bad;
        isbad = c == 2'b11 || g >= 3'd5 || int'(i) >= gsize(g);
        old = isbad ? '0 : tab[g][i];
        nv = old;
        if (isbad) begin est = 2'b11; elat = 1; end
        else if (c == 2'b01 && old[115]) begin est = 2'b01; elat = 3; end
        else if (c == 2'b10 && (!old[115] || old[114:11] != t)) begin est = 2'b10; elat = 3; end
        else begin
            est = 2'b00; elat = 4;
            nv = c == 2'b01 ? {1'b1, t, r} : '0;
            if (mcount < 65535) mcount++;
        end
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; command = c; cmd_group = g; cmd_index = i; cmd_tuple = t; cmd_ruleID = r;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; re_at = 0; we_at = 0; nre = 0; nwe = 0; busy_bad = 0;
        raddr = '0; waddr = '0; wq = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_re) begin nre++; re_at = lat; raddr = {mem_group, mem_addr}; end
            if (mem_we) begin nwe++; we_at = lat; waddr = {mem_group, mem_addr}; wq = mem_wdata; end
            if (!busy || cmd_ready) busy_bad++;
            if (done) break;
        end
        chk("latency", lat, elat);
        chk("status", status, est);
        chk("re_count", nre, isbad ? 0 : 1);
        chk("we_count", nwe, est == 2'b00 ? 1 : 0);
        chk("busy_during", busy_bad, 0);
        chk("count", update_count, mcount);
        if (!isbad) begin
            chk("re_cycle", re_at, 1);
            chk("re_addr", raddr, {g, i});
            chk("table", tab[g][i], nv);
        end
        if (est == 2'b00) begin
            chk("we_cycle", we_at, 3);
            chk("we_addr", waddr, {g, i});
            chk("wdata", wq, nv);
        end
        @(negedge clk);
        chk("back_idle", {cmd_ready, busy, done, status}, {3'b100, est});
    endtask
    task automatic run3(input logic [10:0] i, output int lat);
        @(negedge clk);
        cmd_valid3 = 1'b1; command = 2'b01; cmd_group = 3'd0; cmd_index = i;
        cmd_tuple = rnd_tuple(); cmd_ruleID = 11'($urandom);
        @(posedge clk);
        #1 cmd_valid3 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done3) break;
        end
    endtask
    initial begin
        logic [103:0] t;
        logic [1:0]   c;
        logic [2:0]   g;
        logic [10:0]  i;
        int p, lat, quiet;
        rst = 1'b1; rst3 = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
        command = '0; cmd_group = '0; cmd_index = '0; cmd_tuple = '0; cmd_ruleID = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cmd_ready, mem_re, mem_we, done, busy, status}, 7'b1000000);
        chk("rst_bus", {update_count, mem_group, mem_addr, mem_wdata}, '0);
        rst = 1'b0; rst3 = 1'b0;
        for (int gg = 0; gg < 5; gg++)
            for (int ii = 0; ii < 8; ii++) preload(3'(gg), 11'(ii), '0);
        t = rnd_tuple();
        do_cmd(2'b01, 3'd0, 11'd5, t, 11'h2A);
        preload(3'd1, 11'd7, {1'b1, rnd_tuple(), 11'h11});
        do_cmd(2'b01, 3'd1, 11'd7, rnd_tuple(), 11'h33);
        t = rnd_tuple();
        preload(3'd2, 11'd3, {1'b1, t, 11'h5});
        do_cmd(2'b10, 3'd2, 11'd3, t, 11'h0);
        preload(3'd2, 11'd3, {1'b1, t, 11'h5});
        do_cmd(2'b10, 3'd2, 11'd3, t ^ 104'd1, 11'h0);
        do_cmd(2'b01, 3'd3, 11'd0, rnd_tuple(), 11'h1);
        do_cmd(2'b01, 3'd0, 11'd1738, rnd_tuple(), 11'h1);
        do_cmd(2'b01, 3'd0, 11'd1737, rnd_tuple(), 11'h2);
        do_cmd(2'b01, 3'd5, 11'd0, rnd_tuple(), 11'h1);
        do_cmd(2'b11, 3'd0, 11'd0, rnd_tuple(), 11'h1);
        @(negedge clk);
        cmd_valid = 1'b1; command = 2'b00; cmd_group = 3'd0; cmd_index = 11'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_re || mem_we || !cmd_ready || busy) quiet++;
        end
        chk("nop_quiet", quiet, 0);
        chk("nop_count", update_count, mcount);
        for (int k = 0; k < 60; k++) begin
            p = $urandom_range(0, 9);
            c = p < 4 ? 2'b01 : p < 8 ? 2'b10 : 2'b11;
            g = 3'($urandom_range(0, 6));
            i = $urandom_range(0, 7) == 0 ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 3));
            t = ($urandom_range(0, 1) == 1 && g < 3'd5) ? tab[g][i][114:11] : rnd_tuple();
            do_cmd(c, g, i, t, 11'($urandom));
        end
        preload(3'd4, 11'd20, '0);
        preload(3'd4, 11'd21, '0);
        @(negedge clk);
        force dut.r_update_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_update_count;
        mcount = 65534;
        do_cmd(2'b01, 3'd4, 11'd20, rnd_tuple(), 11'h7);
        do_cmd(2'b01, 3'd4, 11'd21, rnd_tuple(), 11'h8);
        rd3_val = '0;
        run3(11'd9, lat);
        chk("l3_ok_lat", lat, 6);
        chk("l3_ok", {status3, update_count3}, {2'b00, 16'd1});
        rd3_val = {1'b1, 115'd0};
        run3(11'd9, lat);
        chk("l3_coll_lat", lat, 5);
        chk("l3_coll", {status3, update_count3}, {2'b01, 16'd1});
        rd3_val = '0;
        @(negedge clk);
        cmd_valid3 = 1'b1; command = 2'b01; cmd_group = 3'd0; cmd_index = 11'd4;
        @(posedge clk);
        #1 cmd_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        chk("l3_wait_busy", {busy3, mem_re3, mem_we3}, 3'b100);
        #2 rst3 = 1'b1;
        #1 chk("abort_outs", {mem_re3, mem_we3, cmd_ready3, busy3, done3, update_count3}, {5'b00100, 16'd0});
        @(negedge clk);
        rst3 = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_we", we3_n, 1);
        chk("abort_idle", {cmd_ready3, busy3, update_count3}, {2'b10, 16'd0});
        chk("strobe_overlap", both_n, 0);
        chk("wdata_idle_zero", wd_n, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
